// File: rtl/reg_file_dumper_if.sv
// reg_file_dumper_if: start/range, register-file read port and valid/ready word stream of the dumper
//   master (dumper): in start, first, last, rf_rd, ready; out rf_adr, data, adr, valid, busy, done
//   slave (core/consumer side): mirror image of master
interface reg_file_dumper_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              REG_DUMP_start;
  logic [ADDR_W-1:0] REG_DUMP_first;
  logic [ADDR_W-1:0] REG_DUMP_last;
  logic [ADDR_W-1:0] REG_DUMP_rf_adr;
  logic [DATA_W-1:0] REG_DUMP_rf_rd;
  logic [DATA_W-1:0] REG_DUMP_data;
  logic [ADDR_W-1:0] REG_DUMP_adr;
  logic              REG_DUMP_valid;
  logic              REG_DUMP_ready;
  logic              REG_DUMP_busy;
  logic              REG_DUMP_done;
  modport master (
    input  REG_DUMP_start, REG_DUMP_first, REG_DUMP_last, REG_DUMP_rf_rd, REG_DUMP_ready,
    output REG_DUMP_rf_adr, REG_DUMP_data, REG_DUMP_adr, REG_DUMP_valid, REG_DUMP_busy, REG_DUMP_done
  );
  modport slave (
    output REG_DUMP_start, REG_DUMP_first, REG_DUMP_last, REG_DUMP_rf_rd, REG_DUMP_ready,
    input  REG_DUMP_rf_adr, REG_DUMP_data, REG_DUMP_adr, REG_DUMP_valid, REG_DUMP_busy, REG_DUMP_done
  );
endinterface

// File: rtl/reg_file_dumper.sv
// reg_file_dumper: walks a register-file address range and streams each word with its address
//   REG_DUMP_CLK  clock shared with the register-file write port
//   REG_DUMP_RST  synchronous active-high reset
//   bus           reg_file_dumper_if.master (start/range in, rf read port, valid/ready stream, busy/done)
module reg_file_dumper #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               REG_DUMP_CLK,
  input logic               REG_DUMP_RST,
  reg_file_dumper_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_adr;
  // Read address parks at 0 when idle so the core's mux sees a quiet port.
  assign bus.REG_DUMP_rf_adr = (state == IDLE) ? '0 : cur;
  always_ff @(posedge REG_DUMP_CLK) begin
    if (REG_DUMP_RST) begin
      state              <= IDLE;
      cur                <= '0;
      end_adr            <= '0;
      bus.REG_DUMP_data  <= '0;
      bus.REG_DUMP_adr   <= '0;
      bus.REG_DUMP_valid <= 1'b0;
      bus.REG_DUMP_busy  <= 1'b0;
      bus.REG_DUMP_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.REG_DUMP_done <= 1'b0;
          if (bus.REG_DUMP_start) begin
            cur               <= bus.REG_DUMP_first;
            end_adr           <= bus.REG_DUMP_last;
            bus.REG_DUMP_busy <= 1'b1;
            state             <= FETCH;
          end
        end
        FETCH: begin
          // rf_rd is the pre-edge value, so a same-edge write to cur is not captured.
          bus.REG_DUMP_data  <= bus.REG_DUMP_rf_rd;
          bus.REG_DUMP_adr   <= cur;
          bus.REG_DUMP_valid <= 1'b1;
          state              <= PRESENT;
        end
        PRESENT: begin
          if (bus.REG_DUMP_ready) begin
            bus.REG_DUMP_valid <= 1'b0;
            if (cur == end_adr) begin
              bus.REG_DUMP_done <= 1'b1;
              state             <= DONE;
            end else begin
              // Natural ADDR_W overflow gives the wrap past the top register.
              cur   <= cur + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: begin
          bus.REG_DUMP_done <= 1'b0;
          bus.REG_DUMP_busy <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_dumper.sv
// tb_reg_file_dumper: table-driven dumps against a register-file model plus reset and write-race sequences
module tb_reg_file_dumper;
  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         stall;
    bit         mid;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vecs [5];
  reg_file_dumper_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_file_dumper #(.DATA_W(32), .ADDR_W(5)) dut (
    .REG_DUMP_CLK(clk),
    .REG_DUMP_RST(rst),
    .bus         (bus)
  );
  always #5 clk = ~clk;
  assign bus.REG_DUMP_rf_rd = rf[bus.REG_DUMP_rf_adr];
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) rf[i] <= i * 32'h11111111;
    else if (we) rf[wa] <= wd;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic dump(input logic [4:0] first, input logic [4:0] last, input int stall, input bit mid);
    int          n;
    int          w;
    logic [4:0]  a;
    logic [31:0] d0;
    logic [4:0]  a0;
    n = int'(5'(last - first)) + 1;
    a = first;
    bus.REG_DUMP_first = first;
    bus.REG_DUMP_last  = last;
    bus.REG_DUMP_ready = 1'b1;
    bus.REG_DUMP_start = 1'b1;
    @(negedge clk);
    bus.REG_DUMP_start = 1'b0;
    chk("busy_after_start", 32'(bus.REG_DUMP_busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!bus.REG_DUMP_valid && w < 8) begin
        @(negedge clk);
        w++;
      end
      chk("valid_latency", w, 32'd1);
      if (!bus.REG_DUMP_valid) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (mid && k == 1) begin
        bus.REG_DUMP_start = 1'b1;
        bus.REG_DUMP_first = 5'd3;
        bus.REG_DUMP_last  = 5'd4;
      end
      chk("word_adr", 32'(bus.REG_DUMP_adr), 32'(a));
      chk("word_data", bus.REG_DUMP_data, exp_rf[a]);
      chk("word_busy", 32'(bus.REG_DUMP_busy), 32'd1);
      if (stall > 0) begin
        bus.REG_DUMP_ready = 1'b0;
        d0 = bus.REG_DUMP_data;
        a0 = bus.REG_DUMP_adr;
        repeat (stall) @(negedge clk);
        chk("stall_valid", 32'(bus.REG_DUMP_valid), 32'd1);
        chk("stall_data", bus.REG_DUMP_data, d0);
        chk("stall_adr", 32'(bus.REG_DUMP_adr), 32'(a0));
        bus.REG_DUMP_ready = 1'b1;
      end
      @(negedge clk);
      bus.REG_DUMP_start = 1'b0;
      if (k < n - 1) chk("done_early", 32'(bus.REG_DUMP_done), 32'd0);
      a = a + 5'd1;
    end
    chk("done_pulse", 32'(bus.REG_DUMP_done), 32'd1);
    chk("done_valid", 32'(bus.REG_DUMP_valid), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(bus.REG_DUMP_done), 32'd0);
    chk("busy_clear", 32'(bus.REG_DUMP_busy), 32'd0);
    chk("idle_rf_adr", 32'(bus.REG_DUMP_rf_adr), 32'd0);
  endtask
  initial begin
    vecs[0] = '{5'd0, 5'd31, 0, 1'b0};
    vecs[1] = '{5'd30, 5'd1, 0, 1'b0};
    vecs[2] = '{5'd7, 5'd7, 5, 1'b0};
    vecs[3] = '{5'd8, 5'd12, 0, 1'b1};
    vecs[4] = '{5'd31, 5'd0, 2, 1'b0};
    for (int i = 0; i < 32; i++) exp_rf[i] = i * 32'h11111111;
    bus.REG_DUMP_start = 1'b0;
    bus.REG_DUMP_first = '0;
    bus.REG_DUMP_last  = '0;
    bus.REG_DUMP_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    chk("rst_valid", 32'(bus.REG_DUMP_valid), 32'd0);
    chk("rst_busy", 32'(bus.REG_DUMP_busy), 32'd0);
    chk("rst_done", 32'(bus.REG_DUMP_done), 32'd0);
    chk("rst_data", bus.REG_DUMP_data, 32'd0);
    chk("rst_adr", 32'(bus.REG_DUMP_adr), 32'd0);
    chk("rst_rf_adr", 32'(bus.REG_DUMP_rf_adr), 32'd0);
    for (int v = 0; v < 5; v++) dump(vecs[v].first, vecs[v].last, vecs[v].stall, vecs[v].mid);
    bus.REG_DUMP_first = 5'd10;
    bus.REG_DUMP_last  = 5'd20;
    bus.REG_DUMP_ready = 1'b0;
    bus.REG_DUMP_start = 1'b1;
    @(negedge clk);
    bus.REG_DUMP_start = 1'b0;
    chk("fetch_rf_adr", 32'(bus.REG_DUMP_rf_adr), 32'd10);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.REG_DUMP_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.REG_DUMP_valid), 32'd0);
    chk("midrst_busy", 32'(bus.REG_DUMP_busy), 32'd0);
    chk("midrst_done", 32'(bus.REG_DUMP_done), 32'd0);
    chk("midrst_rf_adr", 32'(bus.REG_DUMP_rf_adr), 32'd0);
    @(negedge clk);
    chk("midrst_no_done", 32'(bus.REG_DUMP_done), 32'd0);
    dump(5'd2, 5'd4, 0, 1'b0);
    bus.REG_DUMP_first = 5'd5;
    bus.REG_DUMP_last  = 5'd5;
    bus.REG_DUMP_ready = 1'b0;
    bus.REG_DUMP_start = 1'b1;
    @(negedge clk);
    bus.REG_DUMP_start = 1'b0;
    we = 1'b1;
    wa = 5'd5;
    wd = 32'hDEADBEEF;
    @(negedge clk);
    we = 1'b0;
    chk("race_valid", 32'(bus.REG_DUMP_valid), 32'd1);
    chk("race_old_data", bus.REG_DUMP_data, 32'h55555555);
    bus.REG_DUMP_ready = 1'b1;
    @(negedge clk);
    chk("race_done", 32'(bus.REG_DUMP_done), 32'd1);
    @(negedge clk);
    exp_rf[5] = 32'hDEADBEEF;
    dump(5'd4, 5'd6, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
